// File: rtl/sync_counter_bank_if.sv
// Control and data bundle for sync_counter_bank: the master drives the count
// controls and load values, the slave returns the counter values and flags.
interface sync_counter_bank_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  logic                      en;
  logic                      up;
  logic                      mode;
  logic                      load;
  logic [CHANNELS*WIDTH-1:0] load_data;
  logic [CHANNELS*WIDTH-1:0] out;
  logic [CHANNELS-1:0]       tc;
  logic                      carry_out;

  modport master (
    output en, up, mode, load, load_data,
    input  out, tc, carry_out
  );

  modport slave (
    input  en, up, mode, load, load_data,
    output out, tc, carry_out
  );
endinterface

// File: rtl/sync_counter_bank.sv
// Bank of CHANNELS modulo-MODULUS up/down counters, independent or cascaded.
// Define SYNC_COUNTER_BANK_SATURATE_EN to make the counters saturate instead of wrapping.
module sync_counter_bank #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int MODULUS  = 16
) (
  input logic               clk,
  input logic               rst,
  sync_counter_bank_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0]    r_cnt [CHANNELS];
  logic                r_carry;
  logic [WIDTH-1:0]    w_ld  [CHANNELS];
  logic [CHANNELS-1:0] w_tc;
  logic [CHANNELS-1:0] w_step;
  logic [CHANNELS-1:0] w_hold;

  // The cascade enable is an AND-prefix of lower terminal counts; building it
  // with a running accumulator keeps w_step free of self-reference.
  always_comb begin : tc_step
    logic w_chain;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_tc    = '0;
    w_step  = '0;
    w_chain = bus.en;
    for (int i = 0; i < CHANNELS; i++) begin
      w_tc[i]   = bus.up ? (r_cnt[i] == MAX_VAL) : (r_cnt[i] == '0);
      w_step[i] = bus.mode ? w_chain : bus.en;
      w_chain   = w_chain & w_tc[i];
    end
  end

  always_comb begin : load_clamp
    logic [WIDTH-1:0] w_slice;
    for (int i = 0; i < CHANNELS; i++) begin
      w_slice = bus.load_data[i*WIDTH +: WIDTH];
      w_ld[i] = ({1'b0, w_slice} < MOD_EXT) ? w_slice : MAX_VAL;
    end
  end

`ifdef SYNC_COUNTER_BANK_SATURATE_EN
  logic w_all_tc;
  assign w_all_tc = &w_tc;

  // Cascade holds only when the whole chain sits at its terminal value.
  always_comb begin : sat_hold
    w_hold = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_hold[i] = bus.mode ? (bus.en & w_all_tc) : (w_step[i] & w_tc[i]);
    end
  end
`else
  assign w_hold = '0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every channel sees pre-edge values.
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= '0;
      r_carry <= 1'b0;
    end else if (bus.load) begin
      for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= w_ld[i];
      r_carry <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_step[i] && !w_hold[i]) begin
          if (bus.up) r_cnt[i] <= w_tc[i] ? '0      : r_cnt[i] + WIDTH'(1);
          else        r_cnt[i] <= w_tc[i] ? MAX_VAL : r_cnt[i] - WIDTH'(1);
        end
      end
`ifdef SYNC_COUNTER_BANK_SATURATE_EN
      r_carry <= 1'b0;
`else
      r_carry <= w_step[CHANNELS-1] & w_tc[CHANNELS-1];
`endif
    end
  end

  always_comb begin : drive_out
    bus.out = '0;
    for (int i = 0; i < CHANNELS; i++) bus.out[i*WIDTH +: WIDTH] = r_cnt[i];
  end

  assign bus.tc        = w_tc;
  assign bus.carry_out = r_carry;

endmodule

// File: tb/tb_sync_counter_bank.sv
// Scoreboard bench for sync_counter_bank at WIDTH=4, CHANNELS=4, MODULUS=10
// (BCD digits); the reference model treats cascade mode as one 4-digit number.
module tb_sync_counter_bank;

  localparam int W = 4;
  localparam int C = 4;
  localparam int M = 10;
`ifdef SYNC_COUNTER_BANK_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [15:0] out;
    logic        carry;
    logic [3:0]  tc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   m_cnt[C];
  bit   m_carry;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses;

  sync_counter_bank_if #(.WIDTH(W), .CHANNELS(C)) bus ();

  sync_counter_bank #(.WIDTH(W), .CHANNELS(C), .MODULUS(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_out();
    logic [15:0] v = '0;
    for (int i = 0; i < C; i++) v[i*W +: W] = 4'(m_cnt[i]);
    return v;
  endfunction

  function automatic logic [3:0] model_tc(input bit u);
    logic [3:0] t = '0;
    for (int i = 0; i < C; i++) t[i] = u ? (m_cnt[i] == M - 1) : (m_cnt[i] == 0);
    return t;
  endfunction

  // Cascade is modelled as a single base-M number rather than per-digit ripple.
  task automatic model_apply(input bit r, input bit ld_s, input bit e, input bit u,
                             input bit md, input logic [15:0] ld);
    int total, val, pw;
    bit term;
    if (r) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_carry = 0;
    end else if (ld_s) begin
      foreach (m_cnt[i]) m_cnt[i] = (int'(ld[i*W +: W]) < M) ? int'(ld[i*W +: W]) : M - 1;
      m_carry = 0;
    end else if (md) begin
      total = M ** C;
      val = 0; pw = 1;
      for (int i = 0; i < C; i++) begin val += m_cnt[i] * pw; pw *= M; end
      term = u ? (val == total - 1) : (val == 0);
      m_carry = e && term && !SAT;
      if (e && !(SAT && term)) val = u ? (val + 1) % total : (val + total - 1) % total;
      for (int i = 0; i < C; i++) begin m_cnt[i] = val % M; val /= M; end
    end else begin
      m_carry = 0;
      for (int i = 0; i < C; i++) begin
        term = u ? (m_cnt[i] == M - 1) : (m_cnt[i] == 0);
        if (i == C - 1) m_carry = e && term && !SAT;
        if (e && !(SAT && term)) m_cnt[i] = u ? (m_cnt[i] + 1) % M : (m_cnt[i] + M - 1) % M;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit ld_s, input bit e, input bit u,
                       input bit md, input logic [15:0] ld);
    exp_t item;
    rst = r; bus.load = ld_s; bus.en = e; bus.up = u; bus.mode = md; bus.load_data = ld;
    model_apply(r, ld_s, e, u, md, ld);
    sb.push_back('{out: model_out(), carry: m_carry, tc: model_tc(u)});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      item = sb.pop_front();
      check("out", bus.out, item.out);
      check("carry_out", bus.carry_out, item.carry);
      check("tc", bus.tc, item.tc);
    end
  endtask

  initial begin
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_carry = 0;

    // Reset beats load and enable.
    for (int k = 0; k < 3; k++) cycle(1, 1, 1, 1, 0, 16'h1234);
    check("t1_out", bus.out, 16'h0000);
    check("t1_tc", bus.tc, 4'b0000);
    check("t1_carry", bus.carry_out, 1'b0);

    // Cascade up 10 edges, then wrap all digits.
    for (int k = 0; k < 10; k++) cycle(0, 0, 1, 1, 1, 16'h0);
    check("t2_out", bus.out, 16'h0010);
    cycle(0, 1, 1, 1, 1, 16'h9999);
    cycle(0, 0, 1, 1, 1, 16'h0);
    check("t2_wrap", bus.out, SAT ? 16'h9999 : 16'h0000);
    check("t2_carry", bus.carry_out, !SAT);
    cycle(0, 0, 0, 1, 1, 16'h0);
    check("t2_carry_drop", bus.carry_out, 1'b0);

    // Independent up 12 edges.
    cycle(1, 0, 0, 1, 0, 16'h0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(0, 0, 1, 1, 0, 16'h0);
      pulses += int'(bus.carry_out);
    end
    check("t3_out", bus.out, SAT ? 16'h9999 : 16'h2222);
    check("t3_pulses", pulses, SAT ? 0 : 1);

    // Cascade down through zero.
    cycle(0, 1, 0, 0, 1, 16'h0000);
    cycle(0, 0, 1, 0, 1, 16'h0);
    check("t4_wrap", bus.out, SAT ? 16'h0000 : 16'h9999);
    cycle(0, 0, 1, 0, 1, 16'h0);
    check("t4_next", bus.out, SAT ? 16'h0000 : 16'h9998);

    // Load clamps out-of-range digits and ignores en.
    cycle(0, 1, 1, 1, 1, 16'hF305);
    check("t5_clamp", bus.out, 16'h9305);

    // tc follows up immediately, without an edge.
    cycle(0, 1, 0, 1, 0, 16'h0900);
    check("tc_up", bus.tc, 4'b0100);
    bus.up = 1'b0;
    #1;
    check("tc_down", bus.tc, 4'b1011);

    // Mid-count reset, then the all-terminal chain.
    cycle(0, 1, 0, 1, 1, 16'h0457);
    cycle(1, 0, 1, 1, 1, 16'h0);
    check("t6_rst", bus.out, 16'h0000);
    cycle(0, 1, 0, 1, 1, 16'h9999);
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 1, 1, 16'h0);
    check("t6_top", bus.out, SAT ? 16'h9999 : 16'h0002);

    // Randomised mix of controls against the model.
    for (int k = 0; k < 80; k++) begin
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_counter_bank.md
Name: sync_counter_bank

Overview:
- Parametrised bank of CHANNELS synchronous modulo-MODULUS counters, each WIDTH bits wide.
- Counters run either as independent free-running channels or as one cascaded multi-digit counter (e.g. a 4-digit BCD counter).
- Supports up/down direction, parallel load, per-channel terminal-count flags and a registered carry-out pulse.
- Supersedes fixed 4x4-bit free-running counters in display and timing paths.

Parameters:
- WIDTH, 4, bits per channel counter.
- CHANNELS, 4, number of counter channels (>=1).
- MODULUS, 16, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable for channel 0 (cascade) or all channels (independent).
- up  input  1  1 = count up, 0 = count down.
- mode  input  1  0 = independent, 1 = cascade.
- load  input  1  parallel load strobe.
- load_data  input  CHANNELS*WIDTH  load values; channel i at [i*WIDTH +: WIDTH].
- out  output  CHANNELS*WIDTH  counter values, same packing as load_data.
- tc  output  CHANNELS  terminal-count flag per channel, combinational.
- carry_out  output  1  registered one-cycle pulse on wrap of the last channel.

Behaviour:
- Single clock; all state updates on posedge clk. Reset is synchronous, active-high.
- Priority per edge: rst > load > count.
- rst=1: all channels <= 0; carry_out <= 0. tc then reflects the reset value of 0 under the current `up`.
- load=1 (rst=0): channel i <= load_data[i] if load_data[i] < MODULUS, else MODULUS-1. carry_out <= 0. en is ignored that cycle.
- tc[i] = up ? (cnt[i]==MODULUS-1) : (cnt[i]==0). Purely combinational from current count and `up`.
- Step enables:
  - step[0] = en.
  - mode=0: step[i] = en.
  - mode=1: step[i] = step[i-1] & tc[i-1]. This is a combinational ripple-enable; all channels still update on the same edge.
- On step[i]:
  - up=1: cnt <= (cnt==MODULUS-1) ? 0 : cnt+1.
  - up=0: cnt <= (cnt==0) ? MODULUS-1 : cnt-1.
- No step: channel holds its value.
- carry_out <= step[CHANNELS-1] & tc[CHANNELS-1] when rst=0 and load=0.
  - Asserts exactly in the cycle after the last channel wraps; otherwise 0.
  - In mode=0 it tracks wraps of channel CHANNELS-1 only.
- Arithmetic is modulo MODULUS within WIDTH bits. An out-of-range value can never be held.
- Changing mode or up mid-count: no flush. The new setting applies from the next edge, using current counts; tc re-evaluates immediately.
- MODULUS = 2^WIDTH: wrap equals natural binary overflow.
- CHANNELS = 1: mode has no effect.
- Latency: out changes one cycle after the qualifying edge inputs; no pipeline stages.

Optional Feature:
- Macro: SYNC_COUNTER_BANK_SATURATE_EN.
- Defined: counters saturate instead of wrapping.
  - mode=0: a channel at its terminal value with step holds.
  - mode=1: the chain holds when every channel is at its terminal value (all MODULUS-1 up, all 0 down). Lower channels still wrap to feed carries otherwise.
  - carry_out never asserts.
- Undefined: wrap behaviour as above; no saturation logic synthesised.

Test Plan (WIDTH=4, CHANNELS=4, MODULUS=10 unless noted):
1. Reset with load=1, en=1 held high over 3 edges -> out=0x0000, carry_out=0; with up=1, tc=4'b0000.
2. mode=1, up=1, en=1 from 0 for 10 edges -> out=0x0010; load 0x9999 then 1 en edge -> out=0x0000, carry_out=1 for exactly one cycle.
3. mode=0, up=1, en=1 for 12 edges from 0 -> out=0x2222, carry_out pulsed once (edge 10).
4. mode=1, up=0, load 0x0000, 1 en edge -> out=0x9999, carry_out=1; next edge -> 0x9998, carry_out=0.
5. load=1 with en=1, load_data=0xF305 -> out=0x9305 (0xF clamped to 9), no count applied that edge.
6. Mid-count (out=0x0457, mode=1) assert rst one cycle -> out=0x0000 next edge; with SYNC_COUNTER_BANK_SATURATE_EN, load 0x9999 and en 3 edges -> out stays 0x9999, carry_out=0.
